// File: rtl/oam_dma.sv
// oam_dma: FF46 OAM DMA controller, copies LENGTH bytes from {src_hi,00} to DST_BASE.
module oam_dma #(
   parameter logic [15:0] REG_ADDR = 16'hFF46,
   parameter logic [15:0] DST_BASE = 16'hFE00,
   parameter int          LENGTH   = 160
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_w,
   input  logic        cpu_write_enable,
   output logic [7:0]  cpu_data_r,
   output logic        cpu_data_active,
   output logic        dma_active,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_data_w,
   output logic        bus_write_enable,
   input  logic [7:0]  bus_data_r
);
   typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;
   localparam logic [7:0] LAST = 8'(LENGTH - 1);
   state_t     state;
   logic [7:0] src_hi, idx, byte_q, page;
   logic       reg_wr;
   // Echo RAM E0-FF folds down onto C0-DF.
   function automatic logic [7:0] fold(input logic [7:0] s);
      return s < 8'hE0 ? s : s - 8'h20;
   endfunction
   assign page            = fold(src_hi);
   assign reg_wr          = cpu_write_enable && cpu_addr == REG_ADDR;
   assign cpu_data_active = cpu_addr == REG_ADDR && !cpu_write_enable;
   assign bus_data_w      = state == WRITE ? byte_q : 8'h00;
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         idx              <= 8'h00;
         byte_q           <= 8'h00;
         src_hi           <= 8'h00;
         dma_active       <= 1'b0;
         bus_write_enable <= 1'b0;
         bus_addr         <= 16'h0000;
      end else if (reg_wr) begin
         src_hi           <= cpu_data_w;
         state            <= START;
         dma_active       <= 1'b1;
         bus_write_enable <= 1'b0;
         bus_addr         <= {fold(cpu_data_w), 8'h00};
      end else begin
         case (state)
            START: begin
               state    <= READ;
               idx      <= 8'h00;
               bus_addr <= {page, 8'h00};
            end
            READ: begin
               state            <= WRITE;
               byte_q           <= bus_data_r;
               bus_addr         <= DST_BASE + {8'h00, idx};
               bus_write_enable <= 1'b1;
            end
            WRITE: begin
               bus_write_enable <= 1'b0;
               if (idx < LAST) begin
                  state    <= READ;
                  idx      <= idx + 8'd1;
                  bus_addr <= {page, idx + 8'd1};
               end else begin
                  state      <= IDLE;
                  dma_active <= 1'b0;
                  bus_addr   <= 16'h0000;
               end
            end
            default: ;
         endcase
      end
   end
   always_ff @(negedge clk) begin
      if (reset)
         cpu_data_r <= 8'h00;
      else if (cpu_addr == REG_ADDR)
         cpu_data_r <= src_hi;
   end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: transfer-timeline reference model plus directed and random OAM DMA scenarios.
module tb_oam_dma;
   localparam int LEN = 160;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_data_w = 8'h00;
   logic        cpu_write_enable = 1'b0;
   logic [7:0]  cpu_data_r;
   logic        cpu_data_active;
   logic        dma_active;
   logic [15:0] bus_addr;
   logic [7:0]  bus_data_w;
   logic        bus_write_enable;
   logic [7:0]  bus_data_r;
   int          checks = 0, failures = 0;
   int          act_cnt = 0, wr_cnt = 0, cyc = 0;
   logic        started = 1'b0, hi_mix = 1'b0;
   logic [7:0]  tbl [256];
   logic [7:0]  oam [LEN];
   logic        m_act = 1'b0;
   int          m_t = 0;
   logic [7:0]  m_src = 8'h00, m_page = 8'h00;
   logic        exp_act = 1'b0, exp_we = 1'b0;
   logic [15:0] exp_addr = 16'h0000;
   logic [7:0]  exp_dw = 8'h00;

   oam_dma dut (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_w(cpu_data_w),
      .cpu_write_enable(cpu_write_enable), .cpu_data_r(cpu_data_r),
      .cpu_data_active(cpu_data_active), .dma_active(dma_active), .bus_addr(bus_addr),
      .bus_data_w(bus_data_w), .bus_write_enable(bus_write_enable), .bus_data_r(bus_data_r)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return tbl[a[7:0]] ^ (hi_mix ? a[15:8] : 8'h00);
   endfunction
   assign bus_data_r = mem_f(bus_addr);

   // Reference: t counts cycles since the register write; t=1 START, even t reads, odd t writes.
   always @(posedge clk) begin
      int k;
      if (reset) m_act = 1'b0;
      if (reset) m_src = 8'h00;
      else if (cpu_write_enable && cpu_addr == 16'hFF46) begin
         m_src  = cpu_data_w;
         m_page = m_src >= 8'hE0 ? m_src - 8'h20 : m_src;
         m_act  = 1'b1;
         m_t    = 1;
      end else if (m_act) begin
         m_t++;
         if (m_t > 2 * LEN + 1) m_act = 1'b0;
      end
      exp_act = m_act; exp_we = 1'b0; exp_addr = 16'h0000; exp_dw = 8'h00;
      if (m_act && m_t == 1) exp_addr = {m_page, 8'h00};
      else if (m_act && m_t % 2 == 0) begin
         k = (m_t - 2) / 2;
         exp_addr = {m_page, 8'(k)};
      end else if (m_act) begin
         k = (m_t - 3) / 2;
         exp_addr = 16'hFE00 + 16'(k);
         exp_we   = 1'b1;
         exp_dw   = mem_f({m_page, 8'(k)});
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (started) begin
         checks++;
         if (dma_active !== exp_act || bus_write_enable !== exp_we || bus_addr !== exp_addr ||
             ((exp_we || !exp_act) && bus_data_w !== exp_dw)) begin
            failures++;
            $display("FAIL cycle%0d bus: actual act=%b we=%b addr=%h dw=%h required act=%b we=%b addr=%h dw=%h",
                     cyc, dma_active, bus_write_enable, bus_addr, bus_data_w, exp_act, exp_we, exp_addr, exp_dw);
         end
      end
      if (dma_active === 1'b1) act_cnt++;
      if (bus_write_enable === 1'b1) begin
         wr_cnt++;
         if (bus_addr >= 16'hFE00 && bus_addr < 16'hFE00 + LEN) oam[bus_addr - 16'hFE00] = bus_data_w;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      @(posedge clk);
      #1;
      cpu_addr = a; cpu_data_w = d; cpu_write_enable = 1'b1;
      @(posedge clk);
      #1;
      cpu_write_enable = 1'b0; cpu_addr = 16'h0000;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (dma_active !== 1'b0 && n < 1000) begin
         tick(1);
         n++;
      end
      chk(name, {31'd0, dma_active}, 32'd0);
   endtask

   initial begin
      int bad;
      logic [7:0] s;
      for (int i = 0; i < 256; i++) tbl[i] = 8'(i) ^ 8'h5A;
      tick(2);
      chk("reset_dma_active", {31'd0, dma_active}, 0);
      chk("reset_bus_addr", {16'd0, bus_addr}, 0);
      chk("reset_readback", {24'd0, cpu_data_r}, 0);
      reset = 1'b0;
      started = 1'b1;
      // Plain C1 transfer.
      act_cnt = 0; wr_cnt = 0;
      wr(16'hFF46, 8'hC1);
      wait_idle("t1_timeout");
      chk("t1_active_cycles", act_cnt, 321);
      chk("t1_write_count", wr_cnt, 160);
      chk("t1_oam0", {24'd0, oam[0]}, 32'h5A);
      chk("t1_oam159", {24'd0, oam[159]}, 32'hC5);
      bad = 0;
      for (int k = 0; k < LEN; k++) if (oam[k] !== (8'(k) ^ 8'h5A)) bad++;
      chk("t1_oam_bad_bytes", bad, 0);
      // Echo fold and readback.
      hi_mix = 1'b1;
      for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
      wr(16'hFF46, 8'hF3);
      cpu_addr = 16'hFF46;
      tick(1);
      chk("t2_first_read", {16'd0, bus_addr}, 32'hD300);
      chk("t2_readback", {24'd0, cpu_data_r}, 32'hF3);
      chk("t2_data_active", {31'd0, cpu_data_active}, 1);
      cpu_addr = 16'h0000;
      wr_cnt = 0;
      wait_idle("t2_timeout");
      chk("t2_write_count", wr_cnt, 160);
      // Restart during WRITE of byte 40.
      wr_cnt = 0;
      wr(16'hFF46, 8'h80);
      tick(82);
      chk("t3_write40_addr", {16'd0, bus_addr}, 32'hFE28);
      cpu_addr = 16'hFF46; cpu_data_w = 8'h90; cpu_write_enable = 1'b1;
      @(posedge clk);
      #1;
      cpu_write_enable = 1'b0; cpu_addr = 16'h0000;
      act_cnt = 0;
      chk("t3_oam40_page80", {24'd0, oam[40]}, {24'd0, tbl[40] ^ 8'h80});
      chk("t3_start_addr", {16'd0, bus_addr}, 32'h9000);
      chk("t3_start_active", {30'd0, dma_active, bus_write_enable}, 32'h2);
      tick(1);
      chk("t3_reread", {16'd0, bus_addr}, 32'h9000);
      wait_idle("t3_timeout");
      chk("t3_active_cycles", act_cnt, 321);
      chk("t3_write_count", wr_cnt, 201);
      // Reset during READ of byte 100.
      wr(16'hFF46, 8'hC1);
      tick(201);
      chk("t4_read100_addr", {16'd0, bus_addr}, 32'hC164);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t4_dma_off", {31'd0, dma_active}, 0);
      chk("t4_we_off", {31'd0, bus_write_enable}, 0);
      chk("t4_addr_zero", {16'd0, bus_addr}, 0);
      chk("t4_readback", {24'd0, cpu_data_r}, 0);
      wr_cnt = 0;
      tick(20);
      chk("t4_no_writes", wr_cnt, 0);
      // Neighbouring addresses are ignored.
      act_cnt = 0;
      wr(16'hFF45, 8'h77);
      wr(16'hFF47, 8'h66);
      cpu_addr = 16'hFF47;
      tick(1);
      chk("t5_active_ff47", {31'd0, cpu_data_active}, 0);
      cpu_addr = 16'hFF46;
      tick(1);
      chk("t5_src_unchanged", {24'd0, cpu_data_r}, 0);
      cpu_addr = 16'h0000;
      chk("t5_no_transfer", act_cnt, 0);
      // Reset beats a simultaneous register write.
      reset = 1'b1; cpu_addr = 16'hFF46; cpu_data_w = 8'h55; cpu_write_enable = 1'b1;
      tick(1);
      reset = 1'b0; cpu_write_enable = 1'b0;
      tick(2);
      chk("t6_idle", {31'd0, dma_active}, 0);
      chk("t6_src_zero", {24'd0, cpu_data_r}, 0);
      cpu_addr = 16'h0000;
      // Random transfers with random restarts and resets.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
         s = 8'($urandom);
         wr(16'hFF46, s);
         tick($urandom_range(0, 330));
         case ($urandom_range(0, 2))
            0: wr(16'hFF46, 8'($urandom));
            1: begin
               reset = 1'b1;
               tick(1);
               reset = 1'b0;
            end
            default: ;
         endcase
         wait_idle("rand_timeout");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
